// File: rtl/dcache_port_arbiter.sv
// Arbitrates the LSU requesters onto the single dcache request port and steers in-order
// responses back by way of an outstanding-index queue. Define DCACHE_ARB_FIXED_PRIO_EN for fixed priority.
module dcache_port_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 56,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS-1:0]          req_we_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_be_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_PORTS-1:0]          req_gnt_o,
    output logic [NUM_PORTS-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          dc_req_o,
    output logic [ADDR_W-1:0]             dc_addr_o,
    output logic                          dc_we_o,
    output logic [DATA_W/8-1:0]           dc_be_o,
    output logic [DATA_W-1:0]             dc_wdata_o,
    input  logic                          dc_gnt_i,
    input  logic                          dc_rvalid_i,
    input  logic [DATA_W-1:0]             dc_rdata_i,
    output logic                          protocol_err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {StIdle, StReq} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic                 err_q;
    logic [IDX_W-1:0]     q_mem [MAX_OUT];

    logic                 push, pop, arb_en, win_found;
    logic [IDX_W-1:0]     win_idx, start_idx, head_idx;
    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W:0]       scan;

`ifndef DCACHE_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, next_ptr;
    assign next_ptr = (sel_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
`endif

    assign push     = (state_q == StReq) && dc_gnt_i;
    assign pop      = dc_rvalid_i && (count_q != '0);
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign arb_en   = count_d < CNT_W'(MAX_OUT);
    assign head_idx = q_mem[rd_ptr_q];

    // Winner search: first valid port at or after start_idx, wrapping.
    always_comb begin
        cand = req_valid_i;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
        start_idx = '0;
`else
        start_idx = rr_ptr_q;
        if (push) begin
            // Re-arbitration on a grant skips the port just served.
            start_idx   = next_ptr;
            cand[sel_q] = 1'b0;
        end
`endif
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            scan = {1'b0, start_idx} + (IDX_W + 1)'(k);
            if (scan >= (IDX_W + 1)'(NUM_PORTS)) begin
                scan = scan - (IDX_W + 1)'(NUM_PORTS);
            end
            if (!win_found && cand[scan[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found && arb_en) begin
                    state_d = StReq;
                    sel_d   = win_idx;
                end
            end
            StReq: begin
                if (dc_gnt_i) begin
`ifndef DCACHE_ARB_FIXED_PRIO_EN
                    rr_ptr_d = next_ptr;
`endif
                    if (win_found && arb_en) begin
                        sel_d = win_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Payload is forced to zero while idle so the port is quiet outside a request.
    always_comb begin
        dc_req_o    = (state_q == StReq);
        dc_addr_o   = '0;
        dc_we_o     = 1'b0;
        dc_be_o     = '0;
        dc_wdata_o  = '0;
        req_gnt_o   = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = pop ? dc_rdata_i : '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            req_gnt_o[p]   = push && (sel_q == IDX_W'(p));
            rsp_valid_o[p] = pop && (head_idx == IDX_W'(p));
            if (dc_req_o && (sel_q == IDX_W'(p))) begin
                dc_addr_o  = req_addr_i[p*ADDR_W +: ADDR_W];
                dc_we_o    = req_we_i[p];
                dc_be_o    = req_be_i[p*BE_W +: BE_W];
                dc_wdata_o = req_wdata_i[p*DATA_W +: DATA_W];
            end
        end
    end

    assign protocol_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            if (dc_rvalid_i && (count_q == '0)) begin
                err_q <= 1'b1;
            end
`ifndef DCACHE_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_mem[wr_ptr_q] <= sel_q;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter (round-robin build): expected grants and
// responses are queued by the stimulus and checked by a negedge monitor.
module tb_dcache_port_arbiter;

    typedef struct {
        logic [2:0]  gnt;
        logic [55:0] addr;
    } gnt_t;

    typedef struct {
        logic [2:0]  vld;
        logic [63:0] data;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [2:0]   req_valid_i;
    logic [167:0] req_addr_i;
    logic [2:0]   req_we_i;
    logic [23:0]  req_be_i;
    logic [191:0] req_wdata_i;
    logic [2:0]   req_gnt_o;
    logic [2:0]   rsp_valid_o;
    logic [63:0]  rsp_rdata_o;
    logic         dc_req_o;
    logic [55:0]  dc_addr_o;
    logic         dc_we_o;
    logic [7:0]   dc_be_o;
    logic [63:0]  dc_wdata_o;
    logic         dc_gnt_i;
    logic         dc_rvalid_i;
    logic [63:0]  dc_rdata_i;
    logic         protocol_err_o;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    int   total = 0;
    int   bad   = 0;

    dcache_port_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_be_i       (req_be_i),
        .req_wdata_i    (req_wdata_i),
        .req_gnt_o      (req_gnt_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .dc_req_o       (dc_req_o),
        .dc_addr_o      (dc_addr_o),
        .dc_we_o        (dc_we_o),
        .dc_be_o        (dc_be_o),
        .dc_wdata_o     (dc_wdata_o),
        .dc_gnt_i       (dc_gnt_i),
        .dc_rvalid_i    (dc_rvalid_i),
        .dc_rdata_i     (dc_rdata_i),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] addr_of(int p);
        return 56'h40 + 56'h40 * 56'(p);
    endfunction

    function automatic logic [2:0] oh(int p);
        return 3'b001 << p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input int p);
        gnt_t g;
        g.gnt  = oh(p);
        g.addr = addr_of(p);
        exp_gnt.push_back(g);
    endtask

    task automatic push_rsp(input int p, input logic [63:0] d);
        rsp_t r;
        r.vld  = oh(p);
        r.data = d;
        exp_rsp.push_back(r);
    endtask

    // Monitor: every presented grant/response must match the oldest expectation.
    always @(negedge clk) begin
        if (req_gnt_o != 3'b000) begin
            if (exp_gnt.size() == 0) begin
                chk("unexpected_gnt", {61'd0, req_gnt_o}, 64'd0);
            end else begin
                gnt_t g;
                g = exp_gnt.pop_front();
                chk("gnt_port", {61'd0, req_gnt_o}, {61'd0, g.gnt});
                chk("gnt_addr", {8'd0, dc_addr_o}, {8'd0, g.addr});
            end
        end
        if (rsp_valid_o != 3'b000) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", {61'd0, rsp_valid_o}, 64'd0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                chk("rsp_port", {61'd0, rsp_valid_o}, {61'd0, r.vld});
                chk("rsp_data", rsp_rdata_o, r.data);
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_dc_req"}, {63'd0, dc_req_o}, 64'd0);
        chk({tag, "_gnt"}, {61'd0, req_gnt_o}, 64'd0);
        chk({tag, "_rsp_valid"}, {61'd0, rsp_valid_o}, 64'd0);
        chk({tag, "_rdata"}, rsp_rdata_o, 64'd0);
        chk({tag, "_addr"}, {8'd0, dc_addr_o}, 64'd0);
        chk({tag, "_err"}, {63'd0, protocol_err_o}, 64'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_we_i    = '0;
        req_addr_i  = {addr_of(2), addr_of(1), addr_of(0)};
        req_be_i    = {8'hF0, 8'hFF, 8'h0F};
        req_wdata_i = {64'h2222, 64'h1111, 64'h0};
        dc_gnt_i    = 1'b0;
        dc_rvalid_i = 1'b0;
        dc_rdata_i  = '0;
        repeat (2) cyc();
        rst_i = 1'b0;
        #1 chk_quiet("reset");

        // Single store from port 1, granted on its first request cycle.
        req_valid_i = 3'b010;
        req_we_i    = 3'b010;
        #1 chk("t1_idle", {63'd0, dc_req_o}, 64'd0);
        cyc();
        #1 chk("t1_req", {63'd0, dc_req_o}, 64'd1);
        chk("t1_we", {63'd0, dc_we_o}, 64'd1);
        chk("t1_be", {56'd0, dc_be_o}, 64'hFF);
        dc_gnt_i = 1'b1;
        push_gnt(1);
        cyc();
        req_valid_i = '0;
        req_we_i    = '0;
        dc_gnt_i    = 1'b0;
        dc_rvalid_i = 1'b1;
        dc_rdata_i  = 64'hDEAD;
        push_rsp(1, 64'hDEAD);
        #1 chk("t1_back_idle", {63'd0, dc_req_o}, 64'd0);
        cyc();
        dc_rvalid_i = 1'b0;
        rst_i       = 1'b1;
        cyc();
        rst_i = 1'b0;

        // All ports busy, grant every cycle: rotation 0,1,2,0,1,2.
        req_valid_i = 3'b111;
        #1 chk("t2_idle", {63'd0, dc_req_o}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            dc_gnt_i    = 1'b1;
            dc_rvalid_i = (i > 0);
            dc_rdata_i  = 64'h100 + 64'(i);
            req_valid_i = (i == 5) ? 3'b100 : 3'b111;
            push_gnt(i % 3);
            if (i > 0) push_rsp((i - 1) % 3, 64'h100 + 64'(i));
        end
        cyc();
        dc_gnt_i    = 1'b0;
        req_valid_i = '0;
        dc_rvalid_i = 1'b1;
        dc_rdata_i  = 64'h106;
        push_rsp(2, 64'h106);
        #1 chk("t2_done", {63'd0, dc_req_o}, 64'd0);
        cyc();
        dc_rvalid_i = 1'b0;

        // Fill to MAX_OUT with no responses, then free one slot.
        req_valid_i = 3'b111;
        dc_gnt_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            push_gnt(i % 3);
        end
        cyc();
        #1 chk("t3_full_a", {63'd0, dc_req_o}, 64'd0);
        cyc();
        #1 chk("t3_full_b", {63'd0, dc_req_o}, 64'd0);
        dc_rvalid_i = 1'b1;
        dc_rdata_i  = 64'h200;
        push_rsp(0, 64'h200);
        cyc();
        #1 chk("t3_req_after_pop", {63'd0, dc_req_o}, 64'd1);
        // Simultaneous grant and response: oldest port answered, new index appended.
        dc_rdata_i = 64'h201;
        push_gnt(1);
        push_rsp(1, 64'h201);
        cyc();
        dc_rvalid_i = 1'b0;
        push_gnt(2);
        cyc();
        dc_gnt_i    = 1'b0;
        req_valid_i = '0;
        #1 chk("t4_full_again", {63'd0, dc_req_o}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            dc_rvalid_i = 1'b1;
            dc_rdata_i  = 64'h300 + 64'(i);
            push_rsp((i == 0) ? 2 : (i - 1), 64'h300 + 64'(i));
            cyc();
        end
        dc_rvalid_i = 1'b0;

        // Response with nothing outstanding.
        dc_rvalid_i = 1'b1;
        dc_rdata_i  = 64'hBAD;
        #1 chk("t5_rsp_valid", {61'd0, rsp_valid_o}, 64'd0);
        chk("t5_rdata", rsp_rdata_o, 64'd0);
        chk("t5_err_before", {63'd0, protocol_err_o}, 64'd0);
        cyc();
        dc_rvalid_i = 1'b0;
        #1 chk("t5_err_set", {63'd0, protocol_err_o}, 64'd1);
        repeat (2) cyc();
        chk("t5_err_sticky", {63'd0, protocol_err_o}, 64'd1);

        // Reset while requesting with two outstanding.
        req_valid_i = 3'b011;
        cyc();
        dc_gnt_i = 1'b1;
        push_gnt(0);
        cyc();
        req_valid_i = 3'b111;
        push_gnt(1);
        cyc();
        dc_gnt_i = 1'b0;
        rst_i    = 1'b1;
        #1 chk("t6_req_before_rst", {63'd0, dc_req_o}, 64'd1);
        cyc();
        rst_i       = 1'b0;
        req_valid_i = '0;
        #1 chk_quiet("t6_after_rst");
        dc_rvalid_i = 1'b1;
        dc_rdata_i  = 64'h55;
        #1 chk("t6_late_rsp", {61'd0, rsp_valid_o}, 64'd0);
        cyc();
        dc_rvalid_i = 1'b0;
        #1 chk("t6_late_err", {63'd0, protocol_err_o}, 64'd1);
        cyc();

        chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
